// File: rtl/binary_word_serializer.sv
// -----------------------------------------------------------------------------
// binary_word_serializer
//
// Upstream feeder for the serial divisibility-by-7 checker. It accepts a
// parallel word on a Start/Ready handshake and pulses Clear to reset the
// checker. It then shifts the word out MSB-first on String, one bit per clock.
// Done is raised in the cycle where the checker's result reflects the whole
// word.
//
// Optional feature macro: SERIALIZER_SKID_EN
//   Defined   : one-entry skid buffer. Ready = !pending in every state, and
//               back-to-back words run every WIDTH+2 cycles.
//   Undefined : no skid buffer. Ready is high only in IDLE.
//
// Ports:
//   Clock     in   system clock, rising edge
//   Reset     in   asynchronous active-low reset
//   Start     in   load request; accepted when Start && Ready at a rising edge
//   Data_In   in   [WIDTH-1:0] word to serialize, sampled only on acceptance
//   Ready     out  block can accept a word this cycle
//   Clear     out  one-cycle pulse, checker synchronous reset
//   String    out  serial data bit, MSB first
//   Bit_Valid out  String carries a data bit this cycle
//   Last      out  String carries bit 0 this cycle
//   Done      out  one-cycle pulse, checker result valid this cycle
// -----------------------------------------------------------------------------
module binary_word_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Data_In,
    output logic             Ready,
    output logic             Clear,
    output logic             String,
    output logic             Bit_Valid,
    output logic             Last,
    output logic             Done
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StShift,
        StDone
    } state_e;

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             w_accept;

`ifdef SERIALIZER_SKID_EN
    logic             r_pending;
    logic [WIDTH-1:0] r_skid;

    assign Ready = !r_pending;
`else
    assign Ready = (r_state == StIdle);
`endif

    assign w_accept = Start && Ready;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_shift   <= '0;
`ifdef SERIALIZER_SKID_EN
            r_pending <= 1'b0;
            r_skid    <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
`ifdef SERIALIZER_SKID_EN
                    // A word taken into the skid during DONE drains from here.
                    if (r_pending) begin
                        r_shift   <= r_skid;
                        r_pending <= 1'b0;
                        r_state   <= StClear;
                    end else
`endif
                    if (w_accept) begin
                        r_shift <= Data_In;
                        r_state <= StClear;
                    end
                end
                StClear: begin
                    r_cnt   <= CW'(WIDTH - 1);
                    r_state <= StShift;
                end
                StShift: begin
                    r_shift <= {r_shift[WIDTH-2:0], 1'b0};
                    if (r_cnt == '0) begin
                        r_state <= StDone;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StDone: begin
`ifdef SERIALIZER_SKID_EN
                    if (r_pending) begin
                        r_shift   <= r_skid;
                        r_pending <= 1'b0;
                        r_state   <= StClear;
                    end else begin
                        r_state <= StIdle;
                    end
`else
                    r_state <= StIdle;
`endif
                end
                default: r_state <= StIdle;
            endcase

`ifdef SERIALIZER_SKID_EN
            // Ready is low whenever pending is set, so this never collides with
            // the drain above.
            if (w_accept && (r_state != StIdle)) begin
                r_skid    <= Data_In;
                r_pending <= 1'b1;
            end
`endif
        end
    end

    // Outputs are decoded from registered state only.
    assign Clear     = (r_state == StClear);
    assign Bit_Valid = (r_state == StShift);
    assign String    = (r_state == StShift) && r_shift[WIDTH-1];
    assign Last      = (r_state == StShift) && (r_cnt == '0);
    assign Done      = (r_state == StDone);

endmodule

// File: tb/tb_binary_word_serializer.sv
// -----------------------------------------------------------------------------
// tb_binary_word_serializer
//
// Directed bench for binary_word_serializer with WIDTH=8. A small mod-7 model
// stands in for the downstream checker: it clears on Clear and folds in String
// whenever Bit_Valid is high. Its value is compared with hand-computed
// remainders during Done.
// -----------------------------------------------------------------------------
module tb_binary_word_serializer;

    localparam int unsigned WIDTH = 8;
`ifdef SERIALIZER_SKID_EN
    localparam logic SKID = 1'b1;
`else
    localparam logic SKID = 1'b0;
`endif

    logic             Clock;
    logic             Reset;
    logic             Start;
    logic [WIDTH-1:0] Data_In;
    logic             Ready;
    logic             Clear;
    logic             String;
    logic             Bit_Valid;
    logic             Last;
    logic             Done;

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;
    int rem      = 0;

    binary_word_serializer #(
        .WIDTH (WIDTH)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Data_In   (Data_In),
        .Ready     (Ready),
        .Clear     (Clear),
        .String    (String),
        .Bit_Valid (Bit_Valid),
        .Last      (Last),
        .Done      (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (Done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_string"}, 32'(String), 32'd0);
        check({tag, "_valid"},  32'(Bit_Valid), 32'd0);
        check({tag, "_last"},   32'(Last), 32'd0);
        check({tag, "_clear"},  32'(Clear), 32'd0);
        check({tag, "_done"},   32'(Done), 32'd0);
        check({tag, "_ready"},  32'(Ready), 32'd1);
    endtask

    // Full word transaction. Data_In is scrambled after acceptance to show that
    // it is not re-sampled.
    task automatic run_word(input logic [7:0] data, input int exp_rem, input string tag);
        @(negedge Clock);
        Start   = 1'b1;
        Data_In = data;
        @(negedge Clock);
        Start   = 1'b0;
        Data_In = ~data;
        check({tag, "_clear"}, 32'(Clear), 32'd1);
        check({tag, "_clr_valid"}, 32'(Bit_Valid), 32'd0);
        check({tag, "_clr_ready"}, 32'(Ready), 32'(SKID));
        rem = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            check({tag, "_bit"}, 32'(String), 32'(data[7-i]));
            check({tag, "_valid"}, 32'(Bit_Valid), 32'd1);
            check({tag, "_last"}, 32'(Last), 32'(i == 7));
            rem = (rem * 2 + int'(String)) % 7;
        end
        @(negedge Clock);
        check({tag, "_done"}, 32'(Done), 32'd1);
        check({tag, "_rem"}, 32'(rem), 32'(exp_rem));
        check({tag, "_done_valid"}, 32'(Bit_Valid), 32'd0);
        @(negedge Clock);
        check({tag, "_done_off"}, 32'(Done), 32'd0);
        check({tag, "_ready_back"}, 32'(Ready), 32'd1);
    endtask

    int d0;

    initial begin
        Reset   = 1'b0;
        Start   = 1'b0;
        Data_In = '0;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check_idle_outputs("idle");

        // 0x15 = 21, 0xFF = 255, 0x00: remainders 0, 3, 0.
        run_word(8'h15, 0, "w15");
        run_word(8'hFF, 3, "wFF");
        run_word(8'h00, 0, "w00");

`ifndef SERIALIZER_SKID_EN
        // A second Start is held during SHIFT. It must be ignored, and the first
        // word (0x3C = 60, remainder 4) must complete unchanged.
        d0 = done_cnt;
        @(negedge Clock);
        Start   = 1'b1;
        Data_In = 8'h3C;
        @(negedge Clock);
        Start = 1'b0;
        check("ign_clear", 32'(Clear), 32'd1);
        rem = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            if (i == 1) begin
                Start   = 1'b1;
                Data_In = 8'hAA;
            end
            check("ign_bit", 32'(String), 32'(i < 2 ? 0 : (i < 6 ? 1 : 0)));
            check("ign_ready", 32'(Ready), 32'd0);
            rem = (rem * 2 + int'(String)) % 7;
        end
        @(negedge Clock);
        check("ign_done", 32'(Done), 32'd1);
        check("ign_ready_done", 32'(Ready), 32'd0);
        check("ign_rem", 32'(rem), 32'd4);
        Start = 1'b0;
        repeat (3) begin
            @(negedge Clock);
            check("ign_no_clear", 32'(Clear), 32'd0);
            check("ign_no_valid", 32'(Bit_Valid), 32'd0);
        end
        check("ign_one_done", 32'(done_cnt - d0), 32'd1);
`endif

        // Reset asserted during the 4th SHIFT bit aborts the word.
        d0 = done_cnt;
        @(negedge Clock);
        Start   = 1'b1;
        Data_In = 8'h55;
        @(negedge Clock);
        Start = 1'b0;
        repeat (4) @(negedge Clock);
        check("abort_shifting", 32'(Bit_Valid), 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        check_idle_outputs("abort");
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        check_idle_outputs("abort_after");
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_word(8'h07, 0, "w07");

`ifdef SERIALIZER_SKID_EN
        // 0x0E (14, remainder 0) is followed by 0x05 (remainder 5), which is
        // accepted into the skid while the first word is shifting.
        @(negedge Clock);
        Start   = 1'b1;
        Data_In = 8'h0E;
        rem = 0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge Clock);
            if (c == 1) Start = 1'b0;
            if (c == 3) begin
                Start   = 1'b1;
                Data_In = 8'h05;
            end
            if (c == 4) begin
                Start   = 1'b0;
                Data_In = 8'hFF;
            end
            check("skid_clear", 32'(Clear), 32'(c == 1 || c == 11));
            check("skid_done", 32'(Done), 32'(c == 10 || c == 20));
            check("skid_ready", 32'(Ready), 32'(!(c >= 4 && c <= 10)));
            if (c == 10) check("skid_rem1", 32'(rem), 32'd0);
            if (c == 20) check("skid_rem2", 32'(rem), 32'd5);
            if (Clear) rem = 0;
            if (Bit_Valid) rem = (rem * 2 + int'(String)) % 7;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
